tick_scheduler: RTL and testbench

TICK_SCHEDULER -- requirements
Module: tick_scheduler

---
 rtl/tick_scheduler.sv | 172 +++++++++++++++++
 tb/tb_tick_scheduler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_scheduler.sv
// Prescaled base tick feeding four programmable-period channels. Configuration is
// written to shadow registers and becomes active on a tick boundary or a SYNC restart.
module tick_scheduler #(
  parameter int unsigned CLK_FREQ = 12_000_000,
  parameter int unsigned TICK_HZ  = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [2:0]  cfg_addr,
  input  logic [15:0] cfg_data,
  output logic        cfg_err,
  output logic        base_tick,
  output logic [3:0]  ch_pulse,
  output logic [3:0]  ch_clk,
  output logic        pending,
  output logic        running
);
  localparam int unsigned   PRESCALE = CLK_FREQ / TICK_HZ;
  localparam int unsigned   PW       = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SYNC} state_t;

  state_t        r_state;
  state_t        w_next;

  logic [PW-1:0] r_pre;
  logic          r_base_tick;
  logic [3:0]    r_pulse;
  logic [3:0]    r_clk;
  logic [15:0]   r_cnt  [4];
  logic [15:0]   r_sh_p [4];
  logic [15:0]   r_ac_p [4];
  logic [3:0]    r_sh_m;
  logic [3:0]    r_ac_m;
  logic          r_pending;
  logic          r_err;

  logic          w_acc;
  logic          w_wr_shadow;
  logic          w_cmd;
  logic          w_bad;
  logic          w_tick;
  logic          w_stop;
  logic          w_clear;
  logic          w_apply;
  logic [15:0]   w_eff_p [4];
  logic [3:0]    w_eff_m;
  logic [3:0]    w_ch_act;
  logic [3:0]    w_wrap;

  assign w_acc       = cfg_valid && (r_state != S_SYNC);
  assign w_wr_shadow = w_acc && (cfg_addr <= 3'd4);
  assign w_cmd       = w_acc && (cfg_addr == 3'd5);
  assign w_bad       = w_acc && (cfg_addr[2:1] == 2'b11);
  assign w_tick      = (r_state == S_RUN) && (r_pre == PRE_LAST);
  assign w_stop      = (r_state == S_RUN) && w_cmd && !cfg_data[0];
  assign w_clear     = (r_state != S_RUN) || w_stop;
  assign w_apply     = (r_state == S_SYNC) || (w_tick && r_pending);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    cfg_ready = (r_state != S_SYNC);
    running   = (r_state != S_IDLE);
    unique case (r_state)
      S_IDLE: if (w_cmd && cfg_data[0]) w_next = S_RUN;
      S_RUN: begin
        if (w_cmd) begin
          if (!cfg_data[0])     w_next = S_IDLE;
          else if (cfg_data[1]) w_next = S_SYNC;
        end
      end
      S_SYNC:  w_next = S_RUN;
      default: w_next = S_IDLE;
    endcase
  end

  // A pending apply is evaluated with the shadow values so the wrap on that tick
  // already sees the new period and enable mask.
  always_comb begin
    w_eff_p  = '{default: '0};
    w_eff_m  = r_pending ? r_sh_m : r_ac_m;
    w_ch_act = '0;
    w_wrap   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      w_eff_p[i]  = r_pending ? r_sh_p[i] : r_ac_p[i];
      w_ch_act[i] = w_eff_m[i] && (w_eff_p[i] != '0);
      w_wrap[i]   = r_cnt[i] >= (w_eff_p[i] - 16'd1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sh_p <= '{default: '0};
      r_sh_m <= '0;
    end else if (w_wr_shadow) begin
      if (cfg_addr == 3'd4) r_sh_m                 <= cfg_data[3:0];
      else                  r_sh_p[cfg_addr[1:0]] <= cfg_data;
    end
  end

  // In IDLE the active set simply tracks the shadow one cycle behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ac_p <= '{default: '0};
      r_ac_m <= '0;
    end else if ((r_state == S_IDLE) || w_apply) begin
      r_ac_p <= r_sh_p;
      r_ac_m <= r_sh_m;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             r_pending <= 1'b0;
    else if (w_clear)     r_pending <= 1'b0;
    else if (w_wr_shadow) r_pending <= 1'b1;
    else if (w_tick)      r_pending <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_err <= 1'b0;
    else      r_err <= w_bad;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre       <= '0;
      r_base_tick <= 1'b0;
      r_cnt       <= '{default: '0};
      r_pulse     <= '0;
      r_clk       <= '0;
    end else if (w_clear) begin
      r_pre       <= '0;
      r_base_tick <= 1'b0;
      r_cnt       <= '{default: '0};
      r_pulse     <= '0;
      r_clk       <= '0;
    end else begin
      r_base_tick <= w_tick;
      r_pre       <= w_tick ? '0 : r_pre + 1'b1;
      r_pulse     <= '0;
      if (w_tick) begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (!w_ch_act[i]) begin
            r_cnt[i] <= '0;
            r_clk[i] <= 1'b0;
          end else if (w_wrap[i]) begin
            r_cnt[i]   <= '0;
            r_pulse[i] <= 1'b1;
            r_clk[i]   <= ~r_clk[i];
          end else begin
            r_cnt[i] <= r_cnt[i] + 16'd1;
          end
        end
      end
    end
  end

  assign base_tick = r_base_tick;
  assign ch_pulse  = r_pulse;
  assign ch_clk    = r_clk;
  assign pending   = r_pending;
  assign cfg_err   = r_err;

endmodule

// File: tb/tb_tick_scheduler.sv
// Scoreboard bench for tick_scheduler: a cycle-level reference model queues expected
// outputs per clock, a monitor compares them; windowed pulse counts cover the scenarios.
module tb_tick_scheduler;
  localparam int PRE = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [15:0] cfg_data = '0;
  logic        cfg_ready, cfg_err, base_tick, pending, running;
  logic [3:0]  ch_pulse, ch_clk;

  tick_scheduler #(.CLK_FREQ(100), .TICK_HZ(10)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err),
    .base_tick(base_tick), .ch_pulse(ch_pulse), .ch_clk(ch_clk),
    .pending(pending), .running(running)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int w_bt = 0, w_p0 = 0, w_p2 = 0;

  typedef struct { int cyc; logic [12:0] v; } exp_t;
  exp_t q[$];

  // Reference model: running flag, one-cycle restart flag, tick phase and per-channel
  // tick counts; ch_clk is the parity of the number of wraps since the last clear.
  bit          m_run, m_sync, m_pend;
  int          m_phase;
  logic [15:0] m_sh_p [4];
  logic [15:0] m_ac_p [4];
  logic [3:0]  m_sh_m, m_ac_m;
  int          m_cnt [4];
  int          m_wraps [4];

  function automatic void model_reset();
    m_run = 0; m_sync = 0; m_pend = 0; m_phase = 0;
    m_sh_m = '0; m_ac_m = '0;
    for (int i = 0; i < 4; i++) begin
      m_sh_p[i] = '0; m_ac_p[i] = '0; m_cnt[i] = 0; m_wraps[i] = 0;
    end
  endfunction

  function automatic void clear_channels();
    m_phase = 0;
    for (int i = 0; i < 4; i++) begin m_cnt[i] = 0; m_wraps[i] = 0; end
  endfunction

  function automatic void apply_shadow();
    m_ac_m = m_sh_m;
    for (int i = 0; i < 4; i++) m_ac_p[i] = m_sh_p[i];
  endfunction

  function automatic void write_shadow(input bit [2:0] a, input bit [15:0] d);
    if (a == 3'd4) m_sh_m = d[3:0];
    else           m_sh_p[a] = d;
  endfunction

  function automatic void model_step(input bit v, input bit [2:0] a, input bit [15:0] d);
    bit       acc, err, bt;
    bit [3:0] pl, ck;
    exp_t     e;
    acc = v && !m_sync;
    err = acc && (a >= 3'd6);
    bt  = 0;
    pl  = '0;
    if (!m_run) begin
      apply_shadow();
      clear_channels();
      m_pend = 0;
      if (acc && a <= 3'd4) write_shadow(a, d);
      if (acc && a == 3'd5 && d[0]) m_run = 1;
    end else if (m_sync) begin
      apply_shadow();
      clear_channels();
      m_pend = 0;
      m_sync = 0;
    end else if (acc && a == 3'd5 && !d[0]) begin
      clear_channels();
      m_pend = 0;
      m_run  = 0;
    end else begin
      if (m_phase == PRE - 1) begin
        bt = 1;
        m_phase = 0;
        if (m_pend) begin apply_shadow(); m_pend = 0; end
        for (int i = 0; i < 4; i++) begin
          if (m_ac_m[i] && m_ac_p[i] != 0) begin
            if (m_cnt[i] + 1 >= int'(m_ac_p[i])) begin
              m_cnt[i] = 0; pl[i] = 1; m_wraps[i]++;
            end else m_cnt[i]++;
          end else begin
            m_cnt[i] = 0; m_wraps[i] = 0;
          end
        end
      end else m_phase++;
      if (acc && a <= 3'd4) begin write_shadow(a, d); m_pend = 1; end
      if (acc && a == 3'd5 && d[0] && d[1]) m_sync = 1;
    end
    for (int i = 0; i < 4; i++) ck[i] = (m_wraps[i] % 2) == 1;
    e.cyc = cyc + 1;
    e.v   = {!m_sync, err, bt, m_pend, m_run, pl, ck};
    q.push_back(e);
  endfunction

  task automatic chk(input string nm, input int got, input int req);
    n_checks++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, got, req);
    end
  endtask

  task automatic step(input bit v, input bit [2:0] a, input bit [15:0] d);
    cfg_valid = v; cfg_addr = a; cfg_data = d;
    model_step(v, a, d);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic wr(input bit [2:0] a, input bit [15:0] d);
    step(1'b1, a, d);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 3'($urandom), 16'($urandom));
  endtask

  task automatic window(input string nm, input int n, input int e_bt, input int e_p0, input int e_p2);
    #3; w_bt = 0; w_p0 = 0; w_p2 = 0;
    idle(n);
    #3;
    chk({nm, " base_tick count"}, w_bt, e_bt);
    chk({nm, " ch_pulse[0] count"}, w_p0, e_p0);
    chk({nm, " ch_pulse[2] count"}, w_p2, e_p2);
  endtask

  // Monitor: compares the DUT against the expectation queued for this clock.
  initial begin
    exp_t        e;
    logic [12:0] got;
    forever begin
      @(posedge clk); #3;
      got = {cfg_ready, cfg_err, base_tick, pending, running, ch_pulse, ch_clk};
      w_bt += int'(base_tick);
      w_p0 += int'(ch_pulse[0]);
      w_p2 += int'(ch_pulse[2]);
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        n_checks++; n_fail++;
        $display("FAIL stale expectation: cycle %0d not compared at cycle %0d", e.cyc, cyc);
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        n_checks++;
        if (got !== e.v) begin
          n_fail++;
          $display("FAIL outputs cycle %0d {rdy,err,bt,pend,run,pulse,clk}: got %b required %b",
                   cyc, got, e.v);
        end
      end
    end
  end

  initial begin
    bit [2:0]  ra;
    bit [15:0] rd;
    int        r;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", int'({cfg_ready, cfg_err, base_tick, pending, running, ch_pulse, ch_clk}),
        int'(13'b1_0000_0000_0000));
    rst = 1'b1;

    // Single channel, period 3
    wr(3'd0, 16'd3); wr(3'd4, 16'h1); wr(3'd5, 16'h1);
    idle(40);
    window("p0=3", 120, 12, 4, 0);

    // Period change while running is held pending until a tick
    wr(3'd0, 16'd5);
    idle(100);
    window("p0=5", 150, 15, 3, 0);

    // Shrink period below the current count
    wr(3'd0, 16'd8); wr(3'd5, 16'h3);
    idle(43);
    wr(3'd0, 16'd2);
    idle(40);
    window("p0=2", 100, 10, 5, 0);

    // Two channels resynchronised
    wr(3'd0, 16'd3); wr(3'd1, 16'd3); wr(3'd4, 16'h3);
    idle(25);
    wr(3'd5, 16'h3);
    idle(70);

    // Zero period channel and invalid addresses
    wr(3'd2, 16'd0); wr(3'd3, 16'd4); wr(3'd0, 16'd2); wr(3'd4, 16'hF);
    idle(20);
    wr(3'd7, 16'hFFFF);
    idle(5);
    wr(3'd6, 16'h0003);
    window("mask=F p2=0", 100, 10, 5, 0);

    // Randomised traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 11) == 0) begin
        ra = 3'($urandom_range(0, 7));
        case (ra)
          3'd0, 3'd1, 3'd2, 3'd3: rd = 16'($urandom_range(0, 6));
          3'd5: begin
            r  = $urandom_range(0, 9);
            rd = (16'($urandom) & 16'hFFFC) | ((r == 0) ? 16'h0 : (r < 3) ? 16'h3 : 16'h1);
          end
          default: rd = 16'($urandom);
        endcase
        wr(ra, rd);
      end else idle(1);
    end

    // Asynchronous reset between clock edges
    wr(3'd4, 16'hF); wr(3'd5, 16'h1);
    idle(37);
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    chk("async reset outputs", int'({cfg_ready, cfg_err, base_tick, pending, running, ch_pulse, ch_clk}),
        int'(13'b1_0000_0000_0000));
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    wr(3'd5, 16'h1);
    idle(20);
    window("after reset", 100, 10, 0, 0);

    idle(2);
    #5;
    chk("scoreboard drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
